// File: rtl/vend_ctrl.sv
// vend_ctrl: multi-product vending controller.
//
// Accumulates coin credit in nickel units, vends one of N_ITEMS products,
// each with its own price. Change or a cancel refund is paid as a serial
// stream of single coins over a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_nickel/i_dime/i_quarter coin pulses (1/2/5 units)
//   i_sel [N_ITEMS]          one-hot product select pulse
//   i_cancel                 refund request pulse
//   i_chg_ready              coin dispenser accepts a coin this cycle
//   o_credit                 current credit (nickels)
//   o_vend, o_item           product release pulse and its index
//   o_deny                   selection refused, not enough credit
//   o_coin_reject            inserted coin returned
//   o_chg_valid, o_chg_coin  change coin offer (01 nickel, 10 dime, 11 quarter)
//   o_busy                   paying change
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | accept coins, cancel, product selection
// CHANGE | pay out remaining credit one greedy coin at a time

module vend_ctrl #(
   parameter int N_ITEMS  = 4,
   parameter int CREDIT_W = 6,
   parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {6'd13, 6'd10, 6'd7, 6'd5}
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_nickel,
   input  logic                       i_dime,
   input  logic                       i_quarter,
   input  logic [N_ITEMS-1:0]         i_sel,
   input  logic                       i_cancel,
   input  logic                       i_chg_ready,
   output logic [CREDIT_W-1:0]        o_credit,
   output logic                       o_vend,
   output logic [$clog2(N_ITEMS)-1:0] o_item,
   output logic                       o_deny,
   output logic                       o_coin_reject,
   output logic                       o_chg_valid,
   output logic [1:0]                 o_chg_coin,
   output logic                       o_busy
);

   localparam int IDX_W = $clog2(N_ITEMS);

   typedef enum logic {
      IDLE   = 1'b0,
      CHANGE = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                vend_q, vend_d;
   logic [IDX_W-1:0]    item_q, item_d;
   logic                deny_q, deny_d;
   logic                coin_reject_q, coin_reject_d;
   logic                chg_valid_q, chg_valid_d;
   logic [1:0]          chg_coin_q, chg_coin_d;

   logic [1:0]          coin_cnt;
   logic [CREDIT_W-1:0] coin_add;
   logic [CREDIT_W:0]   coin_sum;
   logic                sel_onehot;
   logic [CREDIT_W-1:0] sel_price;
   logic [IDX_W-1:0]    sel_idx;

   // Largest coin not exceeding the remaining credit.
   function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
      if (c >= CREDIT_W'(5))
         return 2'b11;
      else if (c >= CREDIT_W'(2))
         return 2'b10;
      else
         return 2'b01;
   endfunction

   function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] coin);
      case (coin)
         2'b01:   return CREDIT_W'(1);
         2'b10:   return CREDIT_W'(2);
         2'b11:   return CREDIT_W'(5);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      coin_cnt = {1'b0, i_nickel} + {1'b0, i_dime} + {1'b0, i_quarter};
      if (i_quarter)
         coin_add = CREDIT_W'(5);
      else if (i_dime)
         coin_add = CREDIT_W'(2);
      else
         coin_add = CREDIT_W'(1);
      // Extra carry bit flags a deposit that would exceed max credit.
      coin_sum   = {1'b0, credit_q} + {1'b0, coin_add};
      sel_onehot = (i_sel != '0) && ((i_sel & (i_sel - N_ITEMS'(1))) == '0);
      sel_price  = '0;
      sel_idx    = '0;
      for (int k = 0; k < N_ITEMS; k++) begin
         if (i_sel[k]) begin
            sel_price = ITEM_PRICES[k*CREDIT_W +: CREDIT_W];
            sel_idx   = IDX_W'(k);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      vend_d        = 1'b0;
      item_d        = '0;
      deny_d        = 1'b0;
      coin_reject_d = 1'b0;
      chg_valid_d   = 1'b0;
      chg_coin_d    = 2'b00;

      case (state_q)
         IDLE: begin
            if (coin_cnt != 2'd0) begin
               if (coin_cnt != 2'd1 || coin_sum[CREDIT_W])
                  coin_reject_d = 1'b1;
               else
                  credit_d = coin_sum[CREDIT_W-1:0];
            end else if (i_cancel) begin
               if (credit_q != '0)
                  state_d = CHANGE;
            end else if (sel_onehot) begin
               if (credit_q >= sel_price) begin
                  vend_d   = 1'b1;
                  item_d   = sel_idx;
                  credit_d = credit_q - sel_price;
                  if (credit_d != '0)
                     state_d = CHANGE;
               end else begin
                  deny_d = 1'b1;
               end
            end
         end
         CHANGE: begin
            if (coin_cnt != 2'd0)
               coin_reject_d = 1'b1;
            if (chg_valid_q && i_chg_ready) begin
               credit_d = credit_q - coin_value(chg_coin_q);
               if (credit_d == '0)
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Offer is derived from next-cycle credit so it is registered and
      // stays put while the dispenser holds off.
      if (state_d == CHANGE && credit_d != '0) begin
         chg_valid_d = 1'b1;
         chg_coin_d  = greedy_coin(credit_d);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         vend_q        <= 1'b0;
         item_q        <= '0;
         deny_q        <= 1'b0;
         coin_reject_q <= 1'b0;
         chg_valid_q   <= 1'b0;
         chg_coin_q    <= 2'b00;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         vend_q        <= vend_d;
         item_q        <= item_d;
         deny_q        <= deny_d;
         coin_reject_q <= coin_reject_d;
         chg_valid_q   <= chg_valid_d;
         chg_coin_q    <= chg_coin_d;
      end
   end

   assign o_credit      = credit_q;
   assign o_vend        = vend_q;
   assign o_item        = item_q;
   assign o_deny        = deny_q;
   assign o_coin_reject = coin_reject_q;
   assign o_chg_valid   = chg_valid_q;
   assign o_chg_coin    = chg_coin_q;
   assign o_busy        = (state_q == CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       nickel, dime, quarter;
   logic [3:0] sel;
   logic       cancel;
   logic       chg_ready;
   logic [5:0] credit;
   logic       vend;
   logic [1:0] item;
   logic       deny;
   logic       coin_reject;
   logic       chg_valid;
   logic [1:0] chg_coin;
   logic       busy;

   typedef struct packed {
      logic [5:0] credit;
      logic       vend;
      logic [1:0] item;
      logic       deny;
      logic       rej;
      logic       valid;
      logic [1:0] coin;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   localparam logic [2:0] NONE = 3'b000;
   localparam logic [2:0] NK   = 3'b001;
   localparam logic [2:0] DM   = 3'b010;
   localparam logic [2:0] QT   = 3'b100;

   always #5 clk = ~clk;

   vend_ctrl #(
      .N_ITEMS    (4),
      .CREDIT_W   (6),
      .ITEM_PRICES({6'd13, 6'd10, 6'd7, 6'd5})
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_nickel     (nickel),
      .i_dime       (dime),
      .i_quarter    (quarter),
      .i_sel        (sel),
      .i_cancel     (cancel),
      .i_chg_ready  (chg_ready),
      .o_credit     (credit),
      .o_vend       (vend),
      .o_item       (item),
      .o_deny       (deny),
      .o_coin_reject(coin_reject),
      .o_chg_valid  (chg_valid),
      .o_chg_coin   (chg_coin),
      .o_busy       (busy)
   );

   function automatic exp_t mk(input int c, input logic v, input int it, input logic d,
                               input logic r, input logic cv, input logic [1:0] cc,
                               input logic b);
      exp_t e;
      e.credit = 6'(c);
      e.vend   = v;
      e.item   = 2'(it);
      e.deny   = d;
      e.rej    = r;
      e.valid  = cv;
      e.coin   = cc;
      e.busy   = b;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_total++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      chk("credit",      8'(credit),      8'(e.credit));
      chk("vend",        8'(vend),        8'(e.vend));
      chk("deny",        8'(deny),        8'(e.deny));
      chk("coin_reject", 8'(coin_reject), 8'(e.rej));
      chk("chg_valid",   8'(chg_valid),   8'(e.valid));
      chk("busy",        8'(busy),        8'(e.busy));
      if (e.vend)
         chk("item", 8'(item), 8'(e.item));
      if (e.valid || !rst_n)
         chk("chg_coin", 8'(chg_coin), 8'(e.coin));
   endtask

   // Drive one cycle of inputs, queue the expected response, check after the edge.
   task automatic step(input logic [2:0] coins, input logic [3:0] s, input logic c,
                       input logic rdy, input exp_t e);
      @(negedge clk);
      {quarter, dime, nickel} = coins;
      sel       = s;
      cancel    = c;
      chg_ready = rdy;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      int cr;
      logic [1:0] gc;
      rst_n = 1'b0;
      {quarter, dime, nickel} = NONE;
      sel = 4'b0000; cancel = 1'b0; chg_ready = 1'b0;

      // reset state
      step(NONE, 4'b0000, 0, 0, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b0000, 0, 0, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));
      @(negedge clk);
      rst_n = 1'b1;

      // dime + quarter, vend item 0 (price 5), one dime of change
      step(DM,   4'b0000, 0, 1, mk(2, 0, 0, 0, 0, 0, 2'b00, 0));
      step(QT,   4'b0000, 0, 1, mk(7, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b0001, 0, 1, mk(2, 1, 0, 0, 0, 1, 2'b10, 1));
      step(NONE, 4'b0000, 0, 1, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));

      // deny with insufficient credit, non-one-hot select ignored
      step(DM,   4'b0000, 0, 1, mk(2, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b0010, 0, 1, mk(2, 0, 0, 1, 0, 0, 2'b00, 0));
      step(NONE, 4'b0011, 0, 1, mk(2, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b0000, 0, 1, mk(2, 0, 0, 0, 0, 0, 2'b00, 0));

      // cancel refund of 2, then credit 8 refunded as 11,10,01 back to back
      step(NONE, 4'b0000, 1, 1, mk(2, 0, 0, 0, 0, 1, 2'b10, 1));
      step(NONE, 4'b0000, 0, 1, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b0000, 1, 1, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));
      step(QT,   4'b0000, 0, 1, mk(5, 0, 0, 0, 0, 0, 2'b00, 0));
      step(DM,   4'b0000, 0, 1, mk(7, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NK,   4'b0000, 0, 1, mk(8, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b0000, 1, 1, mk(8, 0, 0, 0, 0, 1, 2'b11, 1));
      step(NONE, 4'b0000, 0, 1, mk(3, 0, 0, 0, 0, 1, 2'b10, 1));
      step(NONE, 4'b0000, 0, 1, mk(1, 0, 0, 0, 0, 1, 2'b01, 1));
      step(NONE, 4'b0000, 0, 1, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));

      // dispenser stall: offer holds, select/cancel ignored in CHANGE
      step(QT,   4'b0000, 0, 0, mk(5, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b0000, 1, 0, mk(5, 0, 0, 0, 0, 1, 2'b11, 1));
      step(NONE, 4'b0000, 0, 0, mk(5, 0, 0, 0, 0, 1, 2'b11, 1));
      step(NONE, 4'b0001, 0, 0, mk(5, 0, 0, 0, 0, 1, 2'b11, 1));
      step(NONE, 4'b0000, 1, 0, mk(5, 0, 0, 0, 0, 1, 2'b11, 1));
      step(NONE, 4'b0000, 0, 1, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));

      // fill to 60, overflow reject, 61, multi-coin reject
      for (int i = 1; i <= 12; i++)
         step(QT, 4'b0000, 0, 1, mk(5 * i, 0, 0, 0, 0, 0, 2'b00, 0));
      step(QT,      4'b0000, 0, 1, mk(60, 0, 0, 0, 1, 0, 2'b00, 0));
      step(NK,      4'b0000, 0, 1, mk(61, 0, 0, 0, 0, 0, 2'b00, 0));
      step(DM | NK, 4'b0000, 0, 1, mk(61, 0, 0, 0, 1, 0, 2'b00, 0));
      // multi-coin with cancel: cancel must be ignored
      step(QT | DM, 4'b0000, 1, 1, mk(61, 0, 0, 0, 1, 0, 2'b00, 0));

      // refund 61, quarter during CHANGE rejected, then drain
      step(NONE, 4'b0000, 1, 0, mk(61, 0, 0, 0, 0, 1, 2'b11, 1));
      step(QT,   4'b0000, 0, 0, mk(61, 0, 0, 0, 1, 1, 2'b11, 1));
      cr = 61;
      while (cr > 0) begin
         if (cr >= 5)      cr -= 5;
         else if (cr >= 2) cr -= 2;
         else              cr -= 1;
         if (cr >= 5)      gc = 2'b11;
         else if (cr >= 2) gc = 2'b10;
         else              gc = 2'b01;
         step(NONE, 4'b0000, 0, 1, mk(cr, 0, 0, 0, 0, cr > 0, gc, cr > 0));
      end

      // credit 13; select with simultaneous coin takes the coin only
      step(QT,   4'b0000, 0, 1, mk(5, 0, 0, 0, 0, 0, 2'b00, 0));
      step(QT,   4'b0000, 0, 1, mk(10, 0, 0, 0, 0, 0, 2'b00, 0));
      step(DM,   4'b0000, 0, 1, mk(12, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NK,   4'b0000, 0, 1, mk(13, 0, 0, 0, 0, 0, 2'b00, 0));
      step(QT,   4'b1000, 0, 1, mk(18, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b1000, 0, 0, mk(5, 1, 3, 0, 0, 1, 2'b11, 1));

      // reset mid-CHANGE discards the remainder
      @(negedge clk);
      rst_n = 1'b0;
      step(NONE, 4'b0000, 0, 0, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));
      @(negedge clk);
      rst_n = 1'b1;
      step(NONE, 4'b0000, 0, 1, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));
      step(NONE, 4'b0000, 0, 1, mk(0, 0, 0, 0, 0, 0, 2'b00, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
